bin_to_seven_segment_scan: RTL

//  Parametrised successor to the 8-bit decimal-to-two-digit display path. Accepts a WIDTH-bit unsigned

---
 rtl/bin_to_seven_segment_scan_pkg.sv | 31 +++
 rtl/bin_to_seven_segment_scan_if.sv | 24 ++
 rtl/bin_to_seven_segment_scan_bcd_seg_decoder.sv | 26 ++
 rtl/bin_to_seven_segment_scan.sv | 129 ++++++++++++
 4 files changed

// File: rtl/bin_to_seven_segment_scan_pkg.sv
// Shared segment patterns, converter FSM states and an elaboration helper
// for the binary-to-scanned-seven-segment display path.
package bin_to_seven_segment_scan_pkg;

  // Segment patterns in {g,f,e,d,c,b,a} order, 1 = lit.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_seven_segment_scan_if.sv
// Value-in handshake plus display-side outputs of the scanned seven-segment block.
// slave = the converter/display, master = the value source / observer.
interface bin_to_seven_segment_scan_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;

  modport master (
    output in_valid, bin_in,
    input  in_ready, done, bcd_out, seg, an
  );

  modport slave (
    input  in_valid, bin_in,
    output in_ready, done, bcd_out, seg, an
  );
endinterface

// File: rtl/bin_to_seven_segment_scan_bcd_seg_decoder.sv
// Combinational BCD digit to {g..a} segment pattern; codes 10..15 decode to blank.
module bin_to_seven_segment_scan_bcd_seg_decoder
  import bin_to_seven_segment_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin_to_seven_segment_scan.sv
// Iterative double-dabble converter (WIDTH+2 cycles per accept, in_ready low while busy)
// feeding a continuously scanned, optionally zero-blanked multiplexed seven-segment display.
module bin_to_seven_segment_scan
  import bin_to_seven_segment_scan_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1,
  parameter int ACT_LOW  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  bin_to_seven_segment_scan_if.slave   bus
);

  localparam int DDW = 4*DIGITS + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (pow10(DIGITS) < (64'd1 << WIDTH)) begin : g_bad_cfg
    $error("DIGITS too small to hold every WIDTH-bit value");
  end

  state_t              state, state_nxt;
  logic [DDW-1:0]      dd_reg;
  logic [DDW-1:0]      dd_adj;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] bcd_q;
  logic                done_q;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [DIGITS-1:0]   nz_at;
  logic                show;
  logic [3:0]          digit_sel;
  logic [6:0]          seg_raw;
  logic [DIGITS-1:0]   an_raw;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction is applied to every BCD nibble before the shift.
  for (genvar n = 0; n < DIGITS; n++) begin : g_nib
    localparam int LO = WIDTH + 4*n;
    assign dd_adj[LO +: 4] = (dd_reg[LO +: 4] >= 4'd5) ? dd_reg[LO +: 4] + 4'd3
                                                        : dd_reg[LO +: 4];
  end
  assign dd_adj[WIDTH-1:0] = dd_reg[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      dd_reg <= '0;
      cnt    <= '0;
      bcd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dd_reg <= {{(4*DIGITS){1'b0}}, bus.bin_in};
            cnt    <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          dd_reg <= {dd_adj[DDW-2:0], 1'b0};
          cnt    <= cnt - CW'(1);
        end
        LOAD: begin
          bcd_q  <= dd_reg[DDW-1 -: 4*DIGITS];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // nz_at[i] is set when digit i or any higher digit is non-zero.
  always_comb begin
    logic running;
    running = 1'b0;
    nz_at   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      running  = running | (|bcd_q[4*i +: 4]);
      nz_at[i] = running;
    end
  end

  assign show      = (idx == '0) || (BLANK_LZ == 0) || nz_at[idx];
  assign digit_sel = show ? bcd_q[int'(idx)*4 +: 4] : 4'hF;
  assign an_raw    = DIGITS'(1) << idx;

  bin_to_seven_segment_scan_bcd_seg_decoder u_dec (
    .bcd (digit_sel),
    .seg (seg_raw)
  );

  assign bus.in_ready = (state == IDLE);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.seg      = (ACT_LOW != 0) ? ~seg_raw : seg_raw;
  assign bus.an       = (ACT_LOW != 0) ? ~an_raw  : an_raw;

endmodule
